// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/debug arbiter for the single-port data memory
module dmem_arbiter #(
    parameter int DEPTH        = 128,
    parameter int WAIT_CYCLES  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_err,
    output logic        cpu_stall,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic [31:0] dbg_rdata,
    output logic        dbg_ack,
    output logic        dbg_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam int CW = $clog2(WAIT_CYCLES + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [1:0]    state_q, state_d;
    logic          owner_q, owner_d;   // 0 = CPU, 1 = DBG
    logic          we_q, we_d;
    logic          err_q, err_d;
    logic [29:0]   addr_q, addr_d;     // word index
    logic [31:0]   wdata_q, wdata_d;
    logic [CW-1:0] wait_q, wait_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [31:0]   cpu_rdata_q, cpu_rdata_d;
    logic [31:0]   dbg_rdata_q, dbg_rdata_d;

    logic          dbg_win;
    logic [31:0]   sel_addr;
    logic          bad_addr;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        err_d       = err_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wait_d      = wait_q;
        starve_d    = starve_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;

        dbg_win  = dbg_req & (~cpu_req | (starve_q == SW'(STARVE_LIMIT)));
        sel_addr = dbg_win ? dbg_addr : cpu_addr;
        bad_addr = (sel_addr[1:0] != 2'b00) || (sel_addr[31:2] >= 30'(DEPTH));

        case (state_q)
            S_IDLE: begin
                if (cpu_req | dbg_req) begin
                    owner_d = dbg_win;
                    we_d    = dbg_win ? dbg_we : cpu_we;
                    addr_d  = sel_addr[31:2];
                    wdata_d = dbg_win ? dbg_wdata : cpu_wdata;
                    err_d   = bad_addr;
                    if (dbg_win)
                        starve_d = '0;
                    else if (dbg_req && starve_q != SW'(STARVE_LIMIT))
                        starve_d = starve_q + SW'(1);
                    // Rejected accesses skip the memory entirely and report rdata=0
                    if (bad_addr) begin
                        state_d = S_RESP;
                        if (dbg_win) dbg_rdata_d = '0;
                        else         cpu_rdata_d = '0;
                    end else begin
                        state_d = S_ACCESS;
                        wait_d  = CW'(WAIT_CYCLES);
                    end
                end
            end
            S_ACCESS: begin
                wait_d = wait_q - CW'(1);
                if (wait_q == CW'(1)) begin
                    state_d = S_RESP;
                    if (!we_q) begin
                        if (owner_q) dbg_rdata_d = mem_rdata;
                        else         cpu_rdata_d = mem_rdata;
                    end
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wait_q      <= '0;
            starve_q    <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wait_q      <= wait_d;
            starve_q    <= starve_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    // Write strobe only on the final access cycle so each store gives one write edge
    assign mem_we    = (state_q == S_ACCESS) & we_q & (wait_q == CW'(1));
    assign mem_re    = (state_q == S_ACCESS) & ~we_q;
    assign mem_addr  = {2'b00, addr_q};
    assign mem_wdata = wdata_q;

    assign cpu_ack   = (state_q == S_RESP) & ~owner_q;
    assign dbg_ack   = (state_q == S_RESP) & owner_q;
    assign cpu_err   = cpu_ack & err_q;
    assign dbg_err   = dbg_ack & err_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dbg_rdata = dbg_rdata_q;
    assign cpu_stall = cpu_req & ~cpu_ack;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed bench for dmem_arbiter (WAIT_CYCLES=1 and 3 instances)
module tb_dmem_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    logic a_cpu_req, a_cpu_we, a_cpu_ack, a_cpu_err, a_cpu_stall;
    logic [31:0] a_cpu_addr, a_cpu_wdata, a_cpu_rdata;
    logic a_dbg_req, a_dbg_we, a_dbg_ack, a_dbg_err;
    logic [31:0] a_dbg_addr, a_dbg_wdata, a_dbg_rdata;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic a_mem_we, a_mem_re;

    logic b_cpu_req, b_cpu_we, b_cpu_ack, b_cpu_err, b_cpu_stall;
    logic [31:0] b_cpu_addr, b_cpu_wdata, b_cpu_rdata;
    logic b_dbg_ack, b_dbg_err;
    logic [31:0] b_dbg_rdata;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic b_mem_we, b_mem_re;

    logic [31:0] mem_a [0:127];
    logic [31:0] mem_b [0:127];
    int a_wc = 0, a_rc = 0, b_wc = 0, b_rc = 0;
    logic [31:0] last_we_addr = '0;

    int n_chk = 0, n_fail = 0;

    dmem_arbiter #(.DEPTH(128), .WAIT_CYCLES(1), .STARVE_LIMIT(4)) u_a (
        .clk(clk), .reset(rst_a),
        .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
        .cpu_rdata(a_cpu_rdata), .cpu_ack(a_cpu_ack), .cpu_err(a_cpu_err), .cpu_stall(a_cpu_stall),
        .dbg_req(a_dbg_req), .dbg_we(a_dbg_we), .dbg_addr(a_dbg_addr), .dbg_wdata(a_dbg_wdata),
        .dbg_rdata(a_dbg_rdata), .dbg_ack(a_dbg_ack), .dbg_err(a_dbg_err),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_we(a_mem_we), .mem_re(a_mem_re),
        .mem_rdata(a_mem_rdata)
    );

    dmem_arbiter #(.DEPTH(128), .WAIT_CYCLES(3), .STARVE_LIMIT(4)) u_b (
        .clk(clk), .reset(rst_b),
        .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
        .cpu_rdata(b_cpu_rdata), .cpu_ack(b_cpu_ack), .cpu_err(b_cpu_err), .cpu_stall(b_cpu_stall),
        .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(32'h0), .dbg_wdata(32'h0),
        .dbg_rdata(b_dbg_rdata), .dbg_ack(b_dbg_ack), .dbg_err(b_dbg_err),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we), .mem_re(b_mem_re),
        .mem_rdata(b_mem_rdata)
    );

    assign a_mem_rdata = mem_a[a_mem_addr[6:0]];
    assign b_mem_rdata = mem_b[b_mem_addr[6:0]];

    always @(posedge clk) begin
        if (a_mem_we) begin mem_a[a_mem_addr[6:0]] <= a_mem_wdata; a_wc <= a_wc + 1; end
        if (a_mem_re) a_rc <= a_rc + 1;
        if (b_mem_we) begin mem_b[b_mem_addr[6:0]] <= b_mem_wdata; b_wc <= b_wc + 1; end
        if (b_mem_re) b_rc <= b_rc + 1;
    end

    always @(negedge clk) if (a_mem_we) last_we_addr <= a_mem_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic a_xfer(input bit dbg, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output bit err, output int lat);
        @(negedge clk);
        if (dbg) begin a_dbg_req = 1; a_dbg_we = we; a_dbg_addr = addr; a_dbg_wdata = wdata; end
        else     begin a_cpu_req = 1; a_cpu_we = we; a_cpu_addr = addr; a_cpu_wdata = wdata; end
        lat = 0;
        do begin @(negedge clk); lat++; end while (!(dbg ? a_dbg_ack : a_cpu_ack) && lat < 32);
        rdata = dbg ? a_dbg_rdata : a_cpu_rdata;
        err   = dbg ? a_dbg_err : a_cpu_err;
        a_cpu_req = 0; a_dbg_req = 0;
    endtask

    task automatic b_xfer(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int lat);
        @(negedge clk);
        b_cpu_req = 1; b_cpu_we = we; b_cpu_addr = addr; b_cpu_wdata = wdata;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!b_cpu_ack && lat < 32);
        rdata = b_cpu_rdata;
        b_cpu_req = 0;
    endtask

    initial begin
        logic [31:0] rd;
        bit er;
        int lat, w0, r0, grants, ovl, cyc, gap;
        logic [9:0] order;

        rst_a = 1; rst_b = 1;
        a_cpu_req = 0; a_cpu_we = 0; a_cpu_addr = 0; a_cpu_wdata = 0;
        a_dbg_req = 0; a_dbg_we = 0; a_dbg_addr = 0; a_dbg_wdata = 0;
        b_cpu_req = 0; b_cpu_we = 0; b_cpu_addr = 0; b_cpu_wdata = 0;
        repeat (2) @(negedge clk);
        check("rst_ack", 32'({a_cpu_ack, a_dbg_ack, a_cpu_err, a_dbg_err}), 0);
        check("rst_mem_strobes", 32'({a_mem_we, a_mem_re}), 0);
        check("rst_mem_addr", a_mem_addr, 0);
        check("rst_cpu_rdata", a_cpu_rdata, 0);
        rst_a = 0; rst_b = 0;

        // Store then load through the CPU port
        w0 = a_wc;
        a_xfer(0, 1, 32'h10, 32'hDEADBEEF, rd, er, lat);
        check("t1_st_lat", lat, 2);
        check("t1_we_cnt", a_wc - w0, 1);
        check("t1_we_addr", last_we_addr, 4);
        check("t1_mem_word", mem_a[4], 32'hDEADBEEF);
        a_xfer(0, 0, 32'h10, 0, rd, er, lat);
        check("t1_ld_data", rd, 32'hDEADBEEF);
        check("t1_ld_err", 32'(er), 0);
        check("t1_ld_lat", lat, 2);

        // Misaligned and out-of-range accesses, then the last valid word
        w0 = a_wc; r0 = a_rc;
        a_xfer(0, 0, 32'h12, 0, rd, er, lat);
        check("t2_mis_err", 32'(er), 1);
        check("t2_mis_rdata", rd, 0);
        check("t2_mis_lat", lat, 1);
        a_xfer(0, 0, 32'h200, 0, rd, er, lat);
        check("t2_oor_err", 32'(er), 1);
        check("t2_oor_lat", lat, 1);
        check("t2_no_mem_access", 32'((a_wc - w0) + (a_rc - r0)), 0);
        a_xfer(0, 1, 32'h1FC, 32'hA5A50001, rd, er, lat);
        check("t2_last_st_err", 32'(er), 0);
        a_xfer(0, 0, 32'h1FC, 0, rd, er, lat);
        check("t2_last_ld_data", rd, 32'hA5A50001);

        // Both requesters held: fairness pattern
        @(negedge clk);
        a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 0;
        a_dbg_req = 1; a_dbg_we = 0; a_dbg_addr = 4;
        grants = 0; order = '0; ovl = 0; cyc = 0;
        while (grants < 10 && cyc < 200) begin
            @(negedge clk); cyc++;
            if (a_cpu_ack && a_dbg_ack) ovl++;
            if (a_cpu_ack || a_dbg_ack) begin order[grants] = a_dbg_ack; grants++; end
        end
        a_cpu_req = 0; a_dbg_req = 0;
        check("t3_grants", grants, 10);
        check("t3_order", 32'(order), 32'h210);
        check("t3_overlap", ovl, 0);

        // DBG in flight while CPU requests
        @(negedge clk);
        a_dbg_req = 1; a_dbg_we = 0; a_dbg_addr = 32'h1FC;
        @(negedge clk);
        a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 32'h10;
        #1 check("t4_stall_rise", 32'(a_cpu_stall), 1);
        cyc = 0; gap = 0;
        while (!a_dbg_ack && cyc < 32) begin @(negedge clk); cyc++; end
        check("t4_dbg_rdata", a_dbg_rdata, 32'hA5A50001);
        check("t4_cpu_ack_at_dbg", 32'(a_cpu_ack), 0);
        a_dbg_req = 0;
        cyc = 0;
        do begin
            if (!a_cpu_stall && !a_cpu_ack) gap++;
            @(negedge clk); cyc++;
        end while (!a_cpu_ack && cyc < 32);
        check("t4_cpu_after_dbg", cyc, 3);
        check("t4_stall_gap", gap, 0);
        check("t4_cpu_rdata", a_cpu_rdata, 32'hDEADBEEF);
        check("t4_stall_at_ack", 32'(a_cpu_stall), 0);
        a_cpu_req = 0;

        // WAIT_CYCLES=3: store, then load with address changed mid-access
        w0 = b_wc;
        b_xfer(1, 32'h20, 32'h12345678, rd, lat);
        check("t6_st_lat", lat, 4);
        check("t6_we_cnt", b_wc - w0, 1);
        @(negedge clk);
        b_cpu_req = 1; b_cpu_we = 0; b_cpu_addr = 32'h20;
        r0 = b_rc; lat = 0;
        do begin
            @(negedge clk); lat++;
            if (lat == 1) b_cpu_addr = 32'h24;
        end while (!b_cpu_ack && lat < 32);
        check("t6_ld_lat", lat, 4);
        check("t6_ld_data", b_cpu_rdata, 32'h12345678);
        check("t6_re_cycles", b_rc - r0, 3);
        b_cpu_req = 0;

        // Reset in the second access cycle of a store
        @(negedge clk);
        b_cpu_req = 1; b_cpu_we = 1; b_cpu_addr = 32'h20; b_cpu_wdata = 32'hCAFEF00D;
        w0 = b_wc;
        repeat (2) @(negedge clk);
        rst_b = 1; b_cpu_req = 0;
        #1;
        check("t5_outs_strobes", 32'({b_mem_we, b_mem_re, b_cpu_ack, b_cpu_err, b_cpu_stall}), 0);
        check("t5_mem_addr", b_mem_addr, 0);
        check("t5_cpu_rdata", b_cpu_rdata, 0);
        @(negedge clk);
        rst_b = 0;
        check("t5_no_write", b_wc - w0, 0);
        check("t5_word_kept", mem_b[8], 32'h12345678);
        b_xfer(0, 32'h20, 0, rd, lat);
        check("t5_post_ld_data", rd, 32'h12345678);
        check("t5_post_ld_lat", lat, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
